sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, the successor to the 16-location FIFO used on our datapath buffers. Depth, width, almost-full/almost-empty thresholds and read mode (registered or first-word-fall-through) are set by parameters. It adds a fill-level output, overflow/underflow pulses and a synchronous flush. It sits between same-clock producer/consumer stages where a clock-domain crossing is not needed.

---
 rtl/sync_fifo_param.sv | 138 +++++++++++++
 tb/tb_sync_fifo_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with fill level, almost
// thresholds, overflow/underflow pulses, synchronous flush and a selectable
// read mode (registered read or first-word-fall-through).
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Thresholds resized once to the level width so every flag compare is exact.
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ZERO_LVL   = '0;
  localparam logic [ADDR_WIDTH:0] ONE_LVL    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR  = (ADDR_WIDTH)'(1);

  // Storage is never reset; the pointers alone define what is valid.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   level_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic                  wr_accept;
  logic                  rd_accept;
  logic [ADDR_WIDTH:0]   level_next;

  // Flags come straight from the level register, never from the inputs.
  assign full         = (level_reg == DEPTH_LVL);
  assign empty        = (level_reg == ZERO_LVL);
  assign almost_full  = (level_reg >= AFULL_LVL);
  assign almost_empty = (level_reg <= AEMPTY_LVL);
  assign level        = level_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Accepts are judged on pre-edge state; a flush suppresses both.
  assign wr_accept = wr_en & ~full  & ~clr;
  assign rd_accept = rd_en & ~empty & ~clr;

  // Next fill level: +1 write only, -1 read only, hold otherwise.
  always_comb begin
    level_next = level_reg;
    if (wr_accept && !rd_accept) begin
      level_next = level_reg + ONE_LVL;
    end else if (rd_accept && !wr_accept) begin
      level_next = level_reg - ONE_LVL;
    end
  end

  // Array write port; plain clocked write so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers and level; flush returns them to the reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
      end
      level_reg <= level_next;
    end
  end

  // Error pulses: high for the single cycle after a rejected request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= wr_en & full;
      underflow_reg <= rd_en & empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown from registered pointer/level only; zero while empty
      // so the output is defined out of reset.
      assign rd_data = empty ? '0 : mem[rd_ptr_reg];
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_reg;

      // Registered read: load on an accepted read, hold otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_reg <= '0;
        end else if (clr) begin
          rd_data_reg <= '0;
        end else if (rd_accept) begin
          rd_data_reg <= mem[rd_ptr_reg];
        end
      end

      assign rd_data = rd_data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of the registered-read and FWFT variants.
module tb_sync_fifo_param;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  // Registered-read instance signals
  logic          clr0 = 1'b0, wr_en0 = 1'b0, rd_en0 = 1'b0;
  logic [DW-1:0] wr_data0 = '0;
  logic [DW-1:0] rd_data0;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic [AW:0]   level0;

  // FWFT instance signals
  logic          clr1 = 1'b0, wr_en1 = 1'b0, rd_en1 = 1'b0;
  logic [DW-1:0] wr_data1 = '0;
  logic [DW-1:0] rd_data1;
  logic          full1, empty1, af1, ae1, ovf1, unf1;
  logic [AW:0]   level1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .wr_en(wr_en0), .wr_data(wr_data0),
    .rd_en(rd_en0), .rd_data(rd_data0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .level(level0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .wr_en(wr_en1), .wr_data(wr_data1),
    .rd_en(rd_en1), .rd_data(rd_data1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .level(level1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    #2;
    check("rst_level",   64'(level0), 64'd0);
    check("rst_empty",   64'(empty0), 64'd1);
    check("rst_full",    64'(full0),  64'd0);
    check("rst_ae",      64'(ae0),    64'd1);
    check("rst_af",      64'(af0),    64'd0);
    check("rst_ovf",     64'(ovf0),   64'd0);
    check("rst_unf",     64'(unf0),   64'd0);
    check("rst_rdata",   64'(rd_data0), 64'd0);
    check("rst_rdata_f", 64'(rd_data1), 64'd0);
    check("rst_empty_f", 64'(empty1), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- single word ----------------
    wr_en0 = 1'b1; wr_data0 = 32'h11;
    tick();
    wr_en0 = 1'b0;
    check("w11_empty", 64'(empty0), 64'd0);
    check("w11_level", 64'(level0), 64'd1);
    rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    check("r11_data",  64'(rd_data0), 64'h11);
    check("r11_empty", 64'(empty0), 64'd1);
    check("r11_level", 64'(level0), 64'd0);

    // ---------------- fill to full ----------------
    for (int i = 0; i < 16; i++) begin
      wr_en0 = 1'b1; wr_data0 = 32'(i);
      tick();
      if (i == 12) check("fill_af_l13", 64'(af0), 64'd0);
      if (i == 13) begin
        check("fill_af_l14",   64'(af0),   64'd1);
        check("fill_full_l14", 64'(full0), 64'd0);
      end
    end
    check("fill_full",  64'(full0),  64'd1);
    check("fill_level", 64'(level0), 64'd16);
    wr_data0 = 32'hFF;
    tick();
    wr_en0 = 1'b0;
    check("ovf_pulse", 64'(ovf0),   64'd1);
    check("ovf_level", 64'(level0), 64'd16);
    tick();
    check("ovf_clear", 64'(ovf0), 64'd0);

    // ---------------- drain in order ----------------
    for (int i = 0; i < 16; i++) begin
      rd_en0 = 1'b1;
      tick();
      check($sformatf("drain_%0d", i), 64'(rd_data0), 64'(i));
      if (i == 13) check("drain_ae_l2", 64'(ae0), 64'd1);
      if (i == 12) check("drain_ae_l3", 64'(ae0), 64'd0);
    end
    rd_en0 = 1'b0;
    check("drain_empty", 64'(empty0), 64'd1);

    // ---------------- underflow ----------------
    rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    check("unf_pulse", 64'(unf0),     64'd1);
    check("unf_rdata", 64'(rd_data0), 64'd15);
    check("unf_level", 64'(level0),   64'd0);
    tick();
    check("unf_clear", 64'(unf0), 64'd0);
    wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = 32'h77;
    tick();
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    check("wr_rd_empty_level", 64'(level0), 64'd1);
    check("wr_rd_empty_unf",   64'(unf0),   64'd1);
    rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    check("wr_rd_empty_data", 64'(rd_data0), 64'h77);

    // ---------------- full with simultaneous wr/rd, wrap ----------------
    for (int i = 0; i < 16; i++) begin
      wr_en0 = 1'b1; wr_data0 = 32'h100 + 32'(i);
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = 32'h200 + 32'(c);
      tick();
      // Cycle 0 write is rejected (full), later writes land behind the 16 preloads.
      check($sformatf("stream_%0d", c), 64'(rd_data0),
            (c < 16) ? 64'(32'h100 + 32'(c)) : 64'(32'h200 + 32'(c - 15)));
      if (c == 0) check("stream_ovf0", 64'(ovf0), 64'd1);
      if (c == 1) check("stream_ovf1", 64'(ovf0), 64'd0);
      if (c == 0 || c == 39) check($sformatf("stream_level_%0d", c), 64'(level0), 64'd15);
    end
    wr_en0 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rd_en0 = 1'b1;
      tick();
      check($sformatf("tail_%0d", i), 64'(rd_data0), 64'(32'h219 + 32'(i)));
    end
    rd_en0 = 1'b0;
    check("tail_empty", 64'(empty0), 64'd1);

    // ---------------- FWFT ----------------
    wr_en1 = 1'b1; wr_data1 = 32'h55;
    tick();
    check("fwft_empty", 64'(empty1), 64'd0);
    check("fwft_head",  64'(rd_data1), 64'h55);
    wr_data1 = 32'hEE;
    tick();
    wr_en1 = 1'b0;
    tick();
    check("fwft_hold",  64'(rd_data1), 64'h55);
    check("fwft_level", 64'(level1), 64'd2);
    rd_en1 = 1'b1;
    tick();
    check("fwft_pop1", 64'(rd_data1), 64'hEE);
    tick();
    rd_en1 = 1'b0;
    check("fwft_pop2_empty", 64'(empty1), 64'd1);
    check("fwft_pop2_level", 64'(level1), 64'd0);

    // ---------------- flush ----------------
    for (int i = 0; i < 5; i++) begin
      wr_en0 = 1'b1; wr_data0 = 32'h30 + 32'(i);
      tick();
    end
    wr_en0 = 1'b0;
    check("pre_clr_level", 64'(level0), 64'd5);
    clr0 = 1'b1; wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = 32'h99;
    tick();
    clr0 = 1'b0; wr_en0 = 1'b0; rd_en0 = 1'b0;
    check("clr_level", 64'(level0),   64'd0);
    check("clr_empty", 64'(empty0),   64'd1);
    check("clr_rdata", 64'(rd_data0), 64'd0);
    tick();
    check("clr_ovf", 64'(ovf0), 64'd0);
    check("clr_unf", 64'(unf0), 64'd0);
    wr_en0 = 1'b1; wr_data0 = 32'hAA;
    tick();
    wr_en0 = 1'b0; rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    check("post_clr_data",  64'(rd_data0), 64'hAA);
    check("post_clr_empty", 64'(empty0),   64'd1);

    // ---------------- asynchronous reset mid-operation ----------------
    wr_en0 = 1'b1; wr_data0 = 32'h42;
    tick();
    wr_en0 = 1'b0;
    rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    wr_en0 = 1'b1; wr_data0 = 32'h43;
    tick();
    wr_en0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", 64'(level0),   64'd0);
    check("arst_empty", 64'(empty0),   64'd1);
    check("arst_rdata", 64'(rd_data0), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
